core_sys_panel_mem_arbiter: RTL

//  Shares the single-port 512-bit x 95-word on-chip frame RAM between two Avalon-MM requesters.

---
 rtl/core_sys_panel_mem_arbiter.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/core_sys_panel_mem_arbiter.sv
// Two-requester Avalon-MM arbiter and zero-fill sequencer for the panel frame RAM.
// Define MEM_ARB_FIXED_PRIO_EN for strict A-over-B priority instead of round-robin.
module core_sys_panel_mem_arbiter #(
  parameter int DEPTH = 95,
  parameter int AW = 7,
  parameter int DW = 512
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            a_read,
  input  logic            a_write,
  input  logic [AW-1:0]   a_address,
  input  logic [DW/8-1:0] a_byteenable,
  input  logic [DW-1:0]   a_writedata,
  output logic            a_waitrequest,
  output logic [DW-1:0]   a_readdata,
  output logic            a_readdatavalid,
  input  logic            b_read,
  input  logic            b_write,
  input  logic [AW-1:0]   b_address,
  input  logic [DW/8-1:0] b_byteenable,
  input  logic [DW-1:0]   b_writedata,
  output logic            b_waitrequest,
  output logic [DW-1:0]   b_readdata,
  output logic            b_readdatavalid,
  input  logic            clear_req,
  output logic            busy,
  output logic            err,
  output logic [AW-1:0]   err_addr,
  output logic [AW-1:0]   mem_address,
  output logic [DW/8-1:0] mem_byteenable,
  output logic            mem_chipselect,
  output logic            mem_write,
  output logic            mem_debugaccess,
  output logic            mem_clken,
  output logic [DW-1:0]   mem_writedata,
  input  logic [DW-1:0]   mem_readdata
);
  localparam int BW = DW / 8;
  localparam logic [0:0] ST_ARB = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  logic [0:0]    state;
  logic [AW-1:0] cnt;
  logic          a_pend;
  logic          b_pend;
  logic          arb_en;
  logic          grant_a;
  logic          grant_b;
  logic          sel_rd;
  logic          sel_wr;
  logic          sel_in;
  logic [AW-1:0] sel_addr;
  logic [BW-1:0] sel_be;
  logic [DW-1:0] sel_wd;
  logic [1:0]    vld;
  logic [1:0]    own;
  logic          oor1;
  logic [DW-1:0] rd_q;

  assign a_pend = a_read | a_write;
  assign b_pend = b_read | b_write;
  assign arb_en = !reset && state == ST_ARB && !clear_req;

`ifdef MEM_ARB_FIXED_PRIO_EN
  assign grant_a = arb_en & a_pend;
  assign grant_b = arb_en & b_pend & ~a_pend;
`else
  logic last_b;

  assign grant_a = arb_en & a_pend & (~b_pend | last_b);
  assign grant_b = arb_en & b_pend & ~grant_a;

  // Reset as if B went last so A wins the first conflict.
  always_ff @(posedge clk) begin
    if (reset) last_b <= 1'b1;
    else if (grant_a | grant_b) last_b <= grant_b;
  end
`endif

  assign sel_addr = grant_b ? b_address : a_address;
  assign sel_be   = grant_b ? b_byteenable : a_byteenable;
  assign sel_wd   = grant_b ? b_writedata : a_writedata;
  // Read wins when both strobes are raised.
  assign sel_rd = grant_b ? b_read : (grant_a & a_read);
  assign sel_wr = grant_b ? (b_write & ~b_read)
                          : (grant_a & a_write & ~a_read);
  assign sel_in = {1'b0, sel_addr} < (AW+1)'(DEPTH);

  always_comb begin
    mem_address    = '0;
    mem_byteenable = '0;
    mem_chipselect = 1'b0;
    mem_write      = 1'b0;
    mem_writedata  = '0;
    if (!reset && state == ST_CLEAR) begin
      mem_address    = cnt;
      mem_byteenable = '1;
      mem_chipselect = 1'b1;
      mem_write      = 1'b1;
    end else if (grant_a | grant_b) begin
      mem_address    = sel_addr;
      mem_byteenable = sel_wr ? sel_be : '1;
      mem_chipselect = sel_in;
      mem_write      = sel_wr & sel_in;
      mem_writedata  = sel_wd;
    end
  end

  assign mem_debugaccess = mem_write;
  assign mem_clken       = 1'b1;
  assign a_waitrequest   = ~grant_a;
  assign b_waitrequest   = ~grant_b;
  assign busy            = state == ST_CLEAR;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_ARB;
      cnt      <= '0;
      err      <= 1'b0;
      err_addr <= '0;
    end else begin
      case (state)
        ST_ARB: begin
          if (clear_req) begin
            state <= ST_CLEAR;
            cnt   <= '0;
            err   <= 1'b0;
          end else if ((grant_a | grant_b) && !sel_in) begin
            err <= 1'b1;
            if (!err) err_addr <= sel_addr;
          end
        end
        ST_CLEAR: begin
          if (cnt == AW'(DEPTH - 1)) state <= ST_ARB;
          cnt <= cnt + AW'(1);
        end
        default: state <= ST_ARB;
      endcase
    end
  end

  // Two-stage tracker: stage 0 = RAM q cycle, stage 1 = readdata cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld  <= '0;
      own  <= '0;
      oor1 <= 1'b0;
      rd_q <= '0;
    end else begin
      vld  <= {vld[0], sel_rd};
      own  <= {own[0], grant_b};
      oor1 <= ~sel_in;
      if (vld[0]) rd_q <= oor1 ? '0 : mem_readdata;
    end
  end

  assign a_readdatavalid = vld[1] & ~own[1];
  assign b_readdatavalid = vld[1] & own[1];
  assign a_readdata      = rd_q;
  assign b_readdata      = rd_q;

endmodule
